// File: rtl/main_mem_pkg.sv
// main_mem_pkg: shared pipeline bundles, opcodes, stage state and bundle helpers
package main_mem_pkg;
  localparam int DATA_W = 32;
  typedef enum logic [3:0] {
    ALU_NOP, ALU_ADD, ALU_LDB, ALU_LDBU, ALU_LDH, ALU_LDHU, ALU_LDW, ALU_LLW,
    ALU_STB, ALU_STH, ALU_STW, ALU_SCW, ALU_CACOP, ALU_PRELD
  } aluop_t;
  typedef struct packed {
    logic [31:0] pc;
    aluop_t      aluop;
    logic [31:0] mem_addr;
    logic [4:0]  reg_write_addr;
    logic        reg_write_en;
    logic [31:0] reg_write_data;
    logic        is_exception;
  } ex_mem_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  reg_write_addr;
    logic        reg_write_en;
    logic [31:0] reg_write_data;
    logic        is_exception;
  } mem_wb_t;
  typedef enum logic [1:0] {IDLE, WAIT, HOLD, DRAIN} mem_state_t;
  function automatic logic is_load(ex_mem_t e);
    return !e.is_exception && (e.aluop inside {ALU_LDB, ALU_LDBU, ALU_LDH, ALU_LDHU, ALU_LDW, ALU_LLW});
  endfunction
  function automatic mem_wb_t to_wb(ex_mem_t e, logic [31:0] d);
    return '{pc: e.pc, reg_write_addr: e.reg_write_addr, reg_write_en: e.reg_write_en,
             reg_write_data: d, is_exception: e.is_exception};
  endfunction
endpackage

// File: rtl/main_mem_if.sv
// main_mem_if: execute, ctrl, dcache and write-back signals of the memory stage
interface main_mem_if;
  import main_mem_pkg::*;
  ex_mem_t           mem_i;
  logic              mem_valid_i;
  logic              pause;
  logic              flush;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;
  logic              pause_mem;
  mem_wb_t           mem_o;
  logic              mem_valid_o;
  modport master (output mem_i, mem_valid_i, pause, flush, data_ok, rdata,
                  input pause_mem, mem_o, mem_valid_o);
  modport slave (input mem_i, mem_valid_i, pause, flush, data_ok, rdata,
                 output pause_mem, mem_o, mem_valid_o);
endinterface

// File: rtl/main_mem_load_align.sv
// load_align: selects and sign/zero-extends the loaded byte, half or word
module load_align
  import main_mem_pkg::*;
(
  input  aluop_t      aluop,
  input  logic [1:0]  a,
  input  logic [31:0] rdata,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = 8'(rdata >> {a, 3'b000});
  assign h = a[1] ? rdata[31:16] : rdata[15:0];
  assign data = aluop == ALU_LDB  ? {{24{b[7]}}, b}
              : aluop == ALU_LDBU ? {24'b0, b}
              : aluop == ALU_LDH  ? {{16{h[15]}}, h}
              : aluop == ALU_LDHU ? {16'b0, h}
              : rdata;
endmodule

// File: rtl/main_mem.sv
// main_mem: memory-access stage tracking one outstanding dcache load
module main_mem
  import main_mem_pkg::*;
(
  input logic       clk,
  input logic       rst,
  main_mem_if.slave bus
);
  mem_state_t  state, next;
  ex_mem_t     held;
  logic [31:0] aligned, data_q;
  logic        accept, emit, keep;
  mem_wb_t     wb;
  load_align u_align (.aluop(held.aluop), .a(held.mem_addr[1:0]), .rdata(bus.rdata), .data(aligned));
  assign bus.pause_mem = state == WAIT || state == DRAIN;
  always_comb begin
    accept = state == IDLE && bus.mem_valid_i && !bus.pause && !bus.flush;
    next = bus.flush ? (((state == WAIT || state == DRAIN) && !bus.data_ok) ? DRAIN : IDLE)
         : state == IDLE ? ((accept && is_load(bus.mem_i)) ? WAIT : IDLE)
         : state == WAIT ? (bus.data_ok ? (bus.pause ? HOLD : IDLE) : WAIT)
         : state == HOLD ? (bus.pause ? HOLD : IDLE)
         : (bus.data_ok ? IDLE : DRAIN);
    emit = !bus.flush && ((accept && !is_load(bus.mem_i))
                          || (state == WAIT && bus.data_ok && !bus.pause)
                          || (state == HOLD && !bus.pause));
    wb = state == IDLE ? to_wb(bus.mem_i, bus.mem_i.reg_write_data)
                       : to_wb(held, state == WAIT ? aligned : data_q);
    keep = state == IDLE && bus.pause && !bus.flush;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      held <= '0;
      data_q <= '0;
      bus.mem_o <= '0;
      bus.mem_valid_o <= 1'b0;
    end else begin
      state <= next;
      if (accept) held <= bus.mem_i;
      if (state == WAIT && bus.data_ok) data_q <= aligned;
      if (!keep) bus.mem_valid_o <= emit;
      if (emit) bus.mem_o <= wb;
    end
  end
endmodule

// File: tb/tb_main_mem.sv
// tb_main_mem: directed and randomized checks of main_mem against a reference model
module tb_main_mem;
  import main_mem_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  main_mem_if bus ();
  main_mem dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ref_align(aluop_t op, logic [1:0] a, logic [31:0] rd);
    int unsigned r = rd;
    int unsigned by = (r >> (8 * a)) % 256;
    int unsigned hw = (r >> (16 * (a / 2))) % 65536;
    if (op == ALU_LDB) return by >= 128 ? by - 256 : by;
    if (op == ALU_LDBU) return by;
    if (op == ALU_LDH) return hw >= 32768 ? hw - 65536 : hw;
    if (op == ALU_LDHU) return hw;
    return rd;
  endfunction
  function automatic ex_mem_t mk(aluop_t op, logic [31:0] addr, logic exc);
    ex_mem_t e;
    e.pc = $urandom;
    e.aluop = op;
    e.mem_addr = addr;
    e.reg_write_addr = 5'($urandom);
    e.reg_write_en = 1'b1;
    e.reg_write_data = $urandom;
    e.is_exception = exc;
    return e;
  endfunction
  function automatic mem_wb_t wb_of(ex_mem_t e, logic [31:0] d);
    mem_wb_t w;
    w.pc = e.pc;
    w.reg_write_addr = e.reg_write_addr;
    w.reg_write_en = e.reg_write_en;
    w.reg_write_data = d;
    w.is_exception = e.is_exception;
    return w;
  endfunction
  task automatic run_load(input aluop_t op, input logic [31:0] addr, input logic [31:0] rd,
                          input int delay, input logic [31:0] want, input string tag);
    ex_mem_t e = mk(op, addr, 1'b0);
    int hi = 0;
    chk({tag, "_idle_pause"}, 128'(bus.pause_mem), 128'(0));
    bus.mem_i = e;
    bus.mem_valid_i = 1'b1;
    tick();
    bus.mem_valid_i = 1'b0;
    bus.mem_i = mk(ALU_ADD, $urandom, 1'b0);
    for (int i = 0; i < delay; i++) begin
      hi += int'(bus.pause_mem);
      chk({tag, "_wait_valid"}, 128'(bus.mem_valid_o), 128'(0));
      tick();
    end
    bus.data_ok = 1'b1;
    bus.rdata = rd;
    hi += int'(bus.pause_mem);
    tick();
    bus.data_ok = 1'b0;
    bus.rdata = $urandom;
    chk({tag, "_pause_cycles"}, 128'(hi), 128'(delay + 1));
    chk({tag, "_valid"}, 128'(bus.mem_valid_o), 128'(1));
    chk({tag, "_result"}, 128'(bus.mem_o), 128'(wb_of(e, want)));
    chk({tag, "_pause_after"}, 128'(bus.pause_mem), 128'(0));
    tick();
    chk({tag, "_valid_drop"}, 128'(bus.mem_valid_o), 128'(0));
  endtask
  task automatic run_pass(input ex_mem_t e, input string tag);
    bus.mem_i = e;
    bus.mem_valid_i = 1'b1;
    tick();
    bus.mem_valid_i = 1'b0;
    bus.data_ok = 1'b1;
    chk({tag, "_valid"}, 128'(bus.mem_valid_o), 128'(1));
    chk({tag, "_result"}, 128'(bus.mem_o), 128'(wb_of(e, e.reg_write_data)));
    chk({tag, "_pause"}, 128'(bus.pause_mem), 128'(0));
    tick();
    bus.data_ok = 1'b0;
    chk({tag, "_valid_drop"}, 128'(bus.mem_valid_o), 128'(0));
    chk({tag, "_pause_after"}, 128'(bus.pause_mem), 128'(0));
  endtask
  initial begin
    aluop_t  loads [6] = '{ALU_LDB, ALU_LDBU, ALU_LDH, ALU_LDHU, ALU_LDW, ALU_LLW};
    aluop_t  others [6] = '{ALU_ADD, ALU_STB, ALU_STW, ALU_SCW, ALU_CACOP, ALU_PRELD};
    ex_mem_t e1, e2;
    bus.mem_i = '0;
    bus.mem_valid_i = 1'b0;
    bus.pause = 1'b0;
    bus.flush = 1'b0;
    bus.data_ok = 1'b0;
    bus.rdata = '0;
    tick();
    tick();
    chk("reset_valid", 128'(bus.mem_valid_o), 128'(0));
    chk("reset_mem_o", 128'(bus.mem_o), 128'(0));
    chk("reset_pause", 128'(bus.pause_mem), 128'(0));
    rst = 1'b1;
    tick();
    run_load(ALU_LDB, 32'h1000_0003, 32'h80FF_1234, 0, 32'hFFFF_FF80, "ldb");
    run_load(ALU_LDBU, 32'h1000_0003, 32'h80FF_1234, 1, 32'h0000_0080, "ldbu");
    run_load(ALU_LDH, 32'h2000_0002, 32'h8001_7FFF, 0, 32'hFFFF_8001, "ldh");
    run_load(ALU_LDW, 32'h3000_0000, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF, "ldw");
    run_pass(mk(ALU_STW, 32'h4000_0000, 1'b0), "stw");
    run_pass(mk(ALU_LDW, 32'h4000_0004, 1'b1), "ld_exc");
    e1 = mk(ALU_STW, 32'h5000_0000, 1'b0);
    e2 = mk(ALU_ADD, 32'h0, 1'b0);
    bus.mem_i = e1;
    bus.mem_valid_i = 1'b1;
    tick();
    bus.mem_i = e2;
    bus.pause = 1'b1;
    tick();
    chk("idle_pause_valid", 128'(bus.mem_valid_o), 128'(1));
    chk("idle_pause_hold", 128'(bus.mem_o), 128'(wb_of(e1, e1.reg_write_data)));
    bus.pause = 1'b0;
    tick();
    bus.mem_valid_i = 1'b0;
    chk("idle_pause_next", 128'(bus.mem_o), 128'(wb_of(e2, e2.reg_write_data)));
    bus.mem_i = mk(ALU_STB, 32'h0, 1'b0);
    bus.mem_valid_i = 1'b1;
    bus.flush = 1'b1;
    tick();
    bus.mem_valid_i = 1'b0;
    bus.flush = 1'b0;
    chk("idle_flush_valid", 128'(bus.mem_valid_o), 128'(0));
    chk("idle_flush_pause", 128'(bus.pause_mem), 128'(0));
    bus.mem_i = mk(ALU_LDW, 32'h6000_0000, 1'b0);
    bus.mem_valid_i = 1'b1;
    tick();
    bus.mem_valid_i = 1'b0;
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("drain_pause", 128'(bus.pause_mem), 128'(1));
    chk("drain_valid", 128'(bus.mem_valid_o), 128'(0));
    tick();
    tick();
    chk("drain_still", 128'(bus.pause_mem), 128'(1));
    bus.data_ok = 1'b1;
    tick();
    bus.data_ok = 1'b0;
    chk("drain_exit_pause", 128'(bus.pause_mem), 128'(0));
    chk("drain_exit_valid", 128'(bus.mem_valid_o), 128'(0));
    bus.mem_i = mk(ALU_LDH, 32'h6000_0002, 1'b0);
    bus.mem_valid_i = 1'b1;
    tick();
    bus.mem_valid_i = 1'b0;
    bus.flush = 1'b1;
    bus.data_ok = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.data_ok = 1'b0;
    chk("flush_ok_pause", 128'(bus.pause_mem), 128'(0));
    chk("flush_ok_valid", 128'(bus.mem_valid_o), 128'(0));
    e1 = mk(ALU_LDHU, 32'h7000_0002, 1'b0);
    bus.mem_i = e1;
    bus.mem_valid_i = 1'b1;
    tick();
    bus.mem_valid_i = 1'b0;
    bus.pause = 1'b1;
    bus.data_ok = 1'b1;
    bus.rdata = 32'h8001_7FFF;
    tick();
    bus.data_ok = 1'b0;
    bus.rdata = 32'h1234_5678;
    chk("hold_pause", 128'(bus.pause_mem), 128'(0));
    chk("hold_valid", 128'(bus.mem_valid_o), 128'(0));
    tick();
    bus.pause = 1'b0;
    chk("hold_valid2", 128'(bus.mem_valid_o), 128'(0));
    tick();
    chk("hold_emit_valid", 128'(bus.mem_valid_o), 128'(1));
    chk("hold_emit_data", 128'(bus.mem_o), 128'(wb_of(e1, 32'h0000_8001)));
    tick();
    bus.mem_i = mk(ALU_LDW, 32'h8000_0000, 1'b0);
    bus.mem_valid_i = 1'b1;
    tick();
    bus.mem_valid_i = 1'b0;
    chk("rst_wait_pause", 128'(bus.pause_mem), 128'(1));
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rst_mid_pause", 128'(bus.pause_mem), 128'(0));
    chk("rst_mid_valid", 128'(bus.mem_valid_o), 128'(0));
    chk("rst_mid_mem_o", 128'(bus.mem_o), 128'(0));
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        run_pass(mk(others[$urandom_range(0, 5)], $urandom, 1'b0), "rnd_pass");
      end else begin
        aluop_t      op = loads[$urandom_range(0, 5)];
        logic [31:0] addr = $urandom;
        logic [31:0] rd = $urandom;
        run_load(op, addr, rd, $urandom_range(0, 3), ref_align(op, addr[1:0], rd), "rnd_load");
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
